box_draw_ctrl: RTL and testbench

- FSM that sequences the box-drawing coordinate datapath: x/y input registers, one shared 7-bit adder, and x/y output registers.
- Captures a base x on ld_x and a base y on go, then walks a square of side 2^SIZE_LOG2 in raster order.
- Time-shares the single adder between x and y (selxy) and pulses plot once per pixel toward the VGA adapter.

---
 rtl/box_draw_ctrl.sv | 137 +++++++++++++
 tb/tb_box_draw_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/box_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : box_draw_ctrl
// Purpose  : Sequences the x/y box-drawing datapath and walks a square of
//            2^SIZE_LOG2 pixels per side in raster order.
// Options  : BOX_DRAW_ABORT_EN adds an abort input that stops a draw early.
// Revision : 1.0 - initial release
// ============================================================================
module box_draw_ctrl #(
  parameter int SIZE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_x,
  input  logic       go,
`ifdef BOX_DRAW_ABORT_EN
  input  logic       abort,
`endif
  output logic       ld_rxin,
  output logic       ld_ryin,
  output logic       ld_rxout,
  output logic       ld_ryout,
  output logic       selxy,
  output logic [2:0] inc,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = 2 * SIZE_LOG2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LDX  = 4'd1,
    S_XREL = 4'd2,
    S_LDY  = 4'd3,
    S_CX   = 4'd4,
    S_CY   = 4'd5,
    S_PLOT = 4'd6,
    S_DONE = 4'd7,
    S_GREL = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_abort;

`ifdef BOX_DRAW_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_rxin  = 1'b0;
    ld_ryin  = 1'b0;
    ld_rxout = 1'b0;
    ld_ryout = 1'b0;
    selxy    = 1'b0;
    inc      = '0;
    plot     = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ld_x)    state_d = S_LDX;
        else if (go) state_d = S_LDY;
      end
      S_LDX: begin
        ld_rxin = 1'b1;
        state_d = S_XREL;
      end
      S_XREL: begin
        if (!ld_x) state_d = S_IDLE;
      end
      S_LDY: begin
        ld_ryin = 1'b1;
        cnt_d   = '0;
        state_d = S_CX;
      end
      S_CX: begin
        selxy                = 1'b0;
        inc[SIZE_LOG2-1:0]   = cnt_q[SIZE_LOG2-1:0];
        ld_rxout             = 1'b1;
        state_d              = S_CY;
      end
      S_CY: begin
        selxy                = 1'b1;
        inc[SIZE_LOG2-1:0]   = cnt_q[CNT_W-1:SIZE_LOG2];
        ld_ryout             = 1'b1;
        state_d              = S_PLOT;
      end
      S_PLOT: begin
        plot = 1'b1;
        if (cnt_q == {CNT_W{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_CX;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_GREL;
      end
      S_GREL: begin
        if (!go) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides the drawing states only; the partial box stays on screen.
    if (w_abort && (state_q == S_LDY || state_q == S_CX ||
                    state_q == S_CY  || state_q == S_PLOT)) begin
      state_d = S_GREL;
      cnt_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_box_draw_ctrl.sv
`default_nettype none
// Testbench for box_draw_ctrl: drives ld_x/go with a simple datapath model and
// scoreboards every plotted pixel against a raster-order reference.
module tb_box_draw_ctrl;

`ifdef BOX_DRAW_ABORT_EN
  localparam int SZ = 3;
`else
  localparam int SZ = 2;
`endif
  localparam int SIDE = 1 << SZ;
  localparam int NPIX = SIDE * SIDE;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_x = 1'b0;
  logic       go = 1'b0;
`ifdef BOX_DRAW_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       ld_rxin, ld_ryin, ld_rxout, ld_ryout, selxy, plot, busy, done;
  logic [2:0] inc;

  logic [6:0] xpos = '0, ypos = '0;
  logic [6:0] rx_q, ry_q, xo_q, yo_q;

  int total = 0, bad = 0, cyc = 0;
  logic [13:0] exp_q[$];
  int exp_done = 0, done_seen = 0, plot_seen = 0, rxin_seen = 0, ryin_seen = 0;
  int ldy_cyc = 0, last_plot = 0, max_inc = 0;
  bit first = 1'b0;
  int cur_x = 0;

  box_draw_ctrl #(.SIZE_LOG2(SZ)) dut (
    .clk(clk), .resetn(resetn), .ld_x(ld_x), .go(go),
`ifdef BOX_DRAW_ABORT_EN
    .abort(abort),
`endif
    .ld_rxin(ld_rxin), .ld_ryin(ld_ryin), .ld_rxout(ld_rxout), .ld_ryout(ld_ryout),
    .selxy(selxy), .inc(inc), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: input registers, one shared adder, output registers.
  always @(posedge clk) begin
    if (!resetn) begin
      rx_q <= '0; ry_q <= '0; xo_q <= '0; yo_q <= '0;
    end else begin
      if (ld_rxin)  rx_q <= xpos;
      if (ld_ryin)  ry_q <= ypos;
      if (ld_rxout) xo_q <= (selxy ? ry_q : rx_q) + 7'(inc);
      if (ld_ryout) yo_q <= (selxy ? ry_q : rx_q) + 7'(inc);
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the controller presents a pixel.
  always @(negedge clk) begin
    if (resetn) begin
      if (ld_rxin) rxin_seen++;
      if (ld_ryin) begin ryin_seen++; ldy_cyc = cyc; first = 1'b1; end
      if (int'(inc) > max_inc) max_inc = int'(inc);
      if (plot) begin
        plot_seen++;
        if (first) chk("ldy_to_first_plot", cyc - ldy_cyc, 3);
        else       chk("plot_spacing", cyc - last_plot, 3);
        first = 1'b0;
        last_plot = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          chk("pixel_xy", int'({xo_q, yo_q}), int'(e));
        end
      end
      if (done) begin
        done_seen++;
        chk("done_after_last_plot", cyc - last_plot, 1);
        chk("done_scoreboard_empty", exp_q.size(), 0);
        if (exp_done == 0) chk("unexpected_done", 1, 0);
        else exp_done--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: raster order, column fastest, 7-bit wrap.
  task automatic push_box(input int x, input int y);
    for (int r = 0; r < SIDE; r++)
      for (int c = 0; c < SIDE; c++)
        exp_q.push_back({7'(x + c), 7'(y + r)});
    exp_done++;
  endtask

  task automatic do_ldx(input int x, input int hold);
    int b;
    b = rxin_seen;
    xpos = 7'(x);
    ld_x = 1'b1;
    tick(hold);
    ld_x = 1'b0;
    tick(3);
    chk("ldx_single_load", rxin_seen - b, 1);
    cur_x = x;
  endtask

  task automatic wait_done(input int b);
    for (int k = 0; k < 3 * NPIX + 20 && done_seen == b; k++) tick(1);
  endtask

  task automatic wait_plots(input int target);
    for (int k = 0; k < 3 * NPIX + 20 && plot_seen < target; k++) tick(1);
  endtask

  task automatic draw_box(input int y, input int extra);
    int bd, bp;
    bd = done_seen; bp = plot_seen;
    ypos = 7'(y);
    push_box(cur_x, y);
    go = 1'b1;
    wait_done(bd);
    chk("done_once", done_seen - bd, 1);
    chk("plot_count", plot_seen - bp, NPIX);
    tick(extra + 1);
    chk("busy_until_go_release", int'(busy), 1);
    chk("no_redraw", plot_seen - bp, NPIX);
    go = 1'b0;
    tick(2);
    chk("idle_after_release", int'(busy), 0);
  endtask

  initial begin
    int b, bd, bp, bry;

    // Reset, then quiet idle.
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_outputs", int'({ld_rxin, ld_ryin, ld_rxout, ld_ryout, selxy,
                                inc, plot, busy, done}), 0);
    end

    // Directed box at (10,20) with a long ld_x hold.
    do_ldx(10, 20);
    draw_box(20, 0);
    chk("inc_max", max_inc, SIDE - 1);

    // go held far beyond the draw.
    do_ldx(int'($urandom_range(0, 127)), 3);
    draw_box(int'($urandom_range(0, 127)), 30);

    // Random boxes.
    for (int i = 0; i < 3; i++) begin
      do_ldx(int'($urandom_range(0, 127)), int'($urandom_range(1, 6)));
      draw_box(int'($urandom_range(0, 127)), int'($urandom_range(0, 5)));
    end

    // ld_x and go together: x loads first, draw starts after ld_x release.
    b = rxin_seen; bry = ryin_seen; bd = done_seen;
    xpos = 7'($urandom_range(0, 127));
    ypos = 7'($urandom_range(0, 127));
    cur_x = int'(xpos);
    ld_x = 1'b1; go = 1'b1;
    tick(6);
    chk("simul_ldx_first", rxin_seen - b, 1);
    chk("simul_no_ldy", ryin_seen - bry, 0);
    push_box(cur_x, int'(ypos));
    ld_x = 1'b0;
    wait_done(bd);
    chk("simul_done", done_seen - bd, 1);
    go = 1'b0;
    tick(2);

    // Reset after the 5th plot abandons the box.
    do_ldx(int'($urandom_range(0, 127)), 2);
    bp = plot_seen; bd = done_seen;
    ypos = 7'($urandom_range(0, 127));
    push_box(cur_x, int'(ypos));
    go = 1'b1;
    wait_plots(bp + 5);
    resetn = 1'b0; go = 1'b0;
    exp_q.delete(); exp_done = 0;
    tick(1);
    chk("reset_mid_outputs", int'({ld_rxin, ld_ryin, ld_rxout, ld_ryout, selxy,
                                   inc, plot, busy, done}), 0);
    resetn = 1'b1;
    tick(4);
    chk("reset_mid_plots", plot_seen - bp, 5);
    chk("reset_mid_no_done", done_seen - bd, 0);
    cur_x = 0;  // datapath x register cleared by reset
    draw_box(int'($urandom_range(0, 127)), 0);

`ifdef BOX_DRAW_ABORT_EN
    // Abort after the 9th plot.
    do_ldx(int'($urandom_range(0, 127)), 2);
    bp = plot_seen; bd = done_seen;
    ypos = 7'($urandom_range(0, 127));
    push_box(cur_x, int'(ypos));
    go = 1'b1;
    wait_plots(bp + 9);
    abort = 1'b1;
    exp_q.delete(); exp_done = 0;
    tick(1);
    abort = 1'b0;
    tick(10);
    chk("abort_plots", plot_seen - bp, 9);
    chk("abort_no_done", done_seen - bd, 0);
    chk("abort_busy_go_held", int'(busy), 1);
    go = 1'b0;
    tick(2);
    chk("abort_idle", int'(busy), 0);
    do_ldx(int'($urandom_range(0, 127)), 2);
    draw_box(int'($urandom_range(0, 127)), 2);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("done_drained", exp_done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
